sync_fifo: RTL and testbench

Parametrised synchronous FIFO: a circular buffer with independent read/write pointers, first-word-fall-through output, occupancy count and programmable almost-full/almost-empty thresholds. It is the general-purpose buffering block for single-clock datapaths, replacing fixed-width, fixed-depth shift-register FIFOs. Over/underflow attempts are ignored, never corrupting state. Optional sticky error flags are selected at compile time.

---
 rtl/sync_fifo.sv | 94 +++++++++
 tb/tb_sync_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO: circular buffer, first-word-fall-through output, occupancy flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned DEPTH            = 8,
    parameter int unsigned ALMOST_FULL_THR  = DEPTH - 2,
    parameter int unsigned ALMOST_EMPTY_THR = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_en, rd_en;

    // Status decodes depend only on the count register.
    assign fifo_full    = (count_q == CNT_W'(DEPTH));
    assign fifo_empty   = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(ALMOST_FULL_THR));
    assign almost_empty = (count_q <= CNT_W'(ALMOST_EMPTY_THR));
    assign count        = count_q;
    assign data_out     = fifo_empty ? '0 : mem_q[rd_ptr_q];

    assign wr_en = push & ~fifo_full;
    assign rd_en = pop & ~fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale words are masked by the empty decode.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && fifo_full)  overflow_q  <= 1'b1;
            if (pop  && fifo_empty) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DEPTH=8): directed vector table, corner sequences, random vs queue model.
module tb_sync_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          fifo_full, fifo_empty, almost_full, almost_empty;
    logic [3:0]    count;
    logic          overflow, underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue plus two sticky bits.
    logic [DW-1:0] q[$];
    bit m_ovf, m_unf;

    function automatic void model_step(input logic r, input logic p, input logic o, input logic [DW-1:0] d);
        int n;
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            n = q.size();
            if (p && n == DEPTH) m_ovf = 1'b1;
            if (o && n == 0)     m_unf = 1'b1;
            if (o && n > 0)      void'(q.pop_front());
            if (p && n < DEPTH)  q.push_back(d);
        end
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        int n = q.size();
        chk("m_count", DW'(count), DW'(n));
        chk("m_data_out", data_out, (n > 0) ? q[0] : '0);
        chk("m_full", DW'(fifo_full), DW'(n == DEPTH));
        chk("m_empty", DW'(fifo_empty), DW'(n == 0));
        chk("m_almost_full", DW'(almost_full), DW'(n >= DEPTH - 2));
        chk("m_almost_empty", DW'(almost_empty), DW'(n <= 2));
        chk("m_overflow", DW'(overflow), DW'(ERR_EN & m_ovf));
        chk("m_underflow", DW'(underflow), DW'(ERR_EN & m_unf));
    endtask

    // Drive away from the edge, advance one edge, then compare against the model.
    task automatic cycle(input logic r, input logic p, input logic o, input logic [DW-1:0] d);
        @(negedge clk);
        reset = r; push = p; pop = o; data_in = d;
        @(posedge clk);
        model_step(r, p, o, d);
        #1;
        model_cmp();
    endtask

    typedef struct {
        logic          rst, psh, pp;
        logic [DW-1:0] din;
        int unsigned   ecnt;
        logic [DW-1:0] edout;
        logic          efull, eempty, eaf, eae;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // Directed table: reset, fill with A0..A7, drain.
        tbl[0] = '{1'b1, 1'b0, 1'b0, '0, 0, '0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++)
            tbl[1+i] = '{1'b0, 1'b1, 1'b0, DW'(32'hA0 + i), i + 1, 32'hA0,
                         i == 7, 1'b0, (i + 1) >= 6, (i + 1) <= 2};
        for (int i = 0; i < 8; i++)
            tbl[9+i] = '{1'b0, 1'b0, 1'b1, '0, 7 - i, (i < 7) ? DW'(32'hA1 + i) : '0,
                         1'b0, i == 7, (7 - i) >= 6, (7 - i) <= 2};

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].rst, tbl[i].psh, tbl[i].pp, tbl[i].din);
            chk($sformatf("v%0d_count", i), DW'(count), DW'(tbl[i].ecnt));
            chk($sformatf("v%0d_data_out", i), data_out, tbl[i].edout);
            chk($sformatf("v%0d_full", i), DW'(fifo_full), DW'(tbl[i].efull));
            chk($sformatf("v%0d_empty", i), DW'(fifo_empty), DW'(tbl[i].eempty));
            chk($sformatf("v%0d_af", i), DW'(almost_full), DW'(tbl[i].eaf));
            chk($sformatf("v%0d_ae", i), DW'(almost_empty), DW'(tbl[i].eae));
        end

        // Overflow push of 0xFF while full, then nine pops with one past empty.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, DW'(32'hB0 + i));
        cycle(1'b0, 1'b1, 1'b0, 32'hFF);
        chk("ovf_count", DW'(count), 32'd8);
        chk("ovf_head", data_out, 32'hB0);
        chk("ovf_flag", DW'(overflow), DW'(ERR_EN));
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            chk("drain_no_ff", DW'(data_out == 32'hFF), 32'd0);
            chk("drain_data", data_out, (i < 7) ? DW'(32'hB1 + i) : '0);
        end
        chk("unf_flag", DW'(underflow), DW'(ERR_EN));
        chk("ovf_sticky", DW'(overflow), DW'(ERR_EN));

        // Streaming push+pop at count 3 across pointer wrap.
        cycle(1'b1, 1'b0, 1'b0, '0);
        chk("rst_clears_ovf", DW'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, DW'(32'hC0 + i));
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 1'b1, DW'(32'hC3 + i));
            chk("stream_count", DW'(count), 32'd3);
            chk("stream_head", data_out, DW'(32'hC1 + i));
        end

        // Push+pop while empty, then while full.
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b1, 32'h11);
        chk("pp_empty_count", DW'(count), 32'd1);
        chk("pp_empty_data", data_out, 32'h11);
        chk("pp_empty_unf", DW'(underflow), DW'(ERR_EN));
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, DW'(32'h20 + i));
        cycle(1'b0, 1'b1, 1'b1, 32'hEE);
        chk("pp_full_count", DW'(count), 32'd7);
        chk("pp_full_head", data_out, 32'h20);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            chk("pp_full_no_ee", DW'(data_out == 32'hEE), 32'd0);
        end

        // Reset at count 5 with push high, then 0x33 is the first word.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, DW'(32'h40 + i));
        cycle(1'b1, 1'b1, 1'b0, 32'h55);
        chk("rst_mid_count", DW'(count), 32'd0);
        chk("rst_mid_empty", DW'(fifo_empty), 32'd1);
        chk("rst_mid_data", data_out, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'h33);
        chk("post_rst_head", data_out, 32'h33);
        chk("post_rst_count", DW'(count), 32'd1);

        // Random traffic with biased phases and occasional reset.
        for (int i = 0; i < 600; i++) begin
            int unsigned pb = (i < 200) ? 70 : (i < 400) ? 30 : 50;
            cycle($urandom_range(0, 79) == 0, $urandom_range(0, 99) < pb,
                  $urandom_range(0, 99) < (100 - pb), DW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
